// File: rtl/traffic_light_pkg.sv
// rtl/traffic_light_pkg.sv - lamp encodings, phase enum and phase-to-lamp decode
// Purpose: shared lamp constants, phase-state typedef and the Moore decode
//          from phase to the four lamp values.
// Optional feature: TLC_ALL_RED_EN adds the all-red clearance phase S7.
package traffic_light_pkg;

  typedef logic [2:0] lamp_t;

  localparam lamp_t RED    = 3'b100;
  localparam lamp_t YELLOW = 3'b010;
  localparam lamp_t GREEN  = 3'b001;

  typedef enum logic [2:0] {
    S1 = 3'd0,
    S2 = 3'd1,
    S3 = 3'd2,
    S4 = 3'd3,
    S5 = 3'd4,
`ifdef TLC_ALL_RED_EN
    S6 = 3'd5,
    S7 = 3'd6
`else
    S6 = 3'd5
`endif
  } phase_e;

  typedef struct packed {
    lamp_t m1;
    lamp_t m2;
    lamp_t mt;
    lamp_t s;
  } lamps_t;

  // Unknown encodings decode to all-red so a corrupted state can never
  // show a conflicting green for the one cycle before recovery.
  function automatic lamps_t decode_phase(phase_e p);
    lamps_t l;
    case (p)
      S1:      l = '{m1: GREEN,  m2: GREEN,  mt: RED,    s: RED};
      S2:      l = '{m1: GREEN,  m2: YELLOW, mt: RED,    s: RED};
      S3:      l = '{m1: GREEN,  m2: RED,    mt: GREEN,  s: RED};
      S4:      l = '{m1: YELLOW, m2: RED,    mt: YELLOW, s: RED};
      S5:      l = '{m1: RED,    m2: RED,    mt: RED,    s: GREEN};
      S6:      l = '{m1: RED,    m2: RED,    mt: RED,    s: YELLOW};
      default: l = '{m1: RED,    m2: RED,    mt: RED,    s: RED};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_light_controller_if.sv
// rtl/traffic_light_controller_if.sv - lamp bundle of the traffic light controller
// Purpose: groups the four lamp buses driven by the controller.
// Ports:   light_M1, light_M2, light_MT, light_S (3-bit one-hot lamps)
//          master modport drives the lamps, slave modport observes them.
interface traffic_light_controller_if;
  import traffic_light_pkg::*;

  lamp_t light_M1;
  lamp_t light_M2;
  lamp_t light_MT;
  lamp_t light_S;

  modport master (output light_M1, output light_M2, output light_MT, output light_S);
  modport slave  (input  light_M1, input  light_M2, input  light_MT, input  light_S);

endinterface

// File: rtl/tlc_phase_timer.sv
// rtl/tlc_phase_timer.sv - per-phase cycle counter
// Purpose: counts cycles spent in the current phase.
// Ports:   clk   - clock
//          rst   - synchronous active-low reset, forces count to 0
//          clear - restart count at 0 on the next edge (phase change)
//          count - cycles elapsed in the current phase (CNT_W bits)
module tlc_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/traffic_light_controller.sv
// rtl/traffic_light_controller.sv - six-phase traffic light Moore FSM
// Purpose: cycles S1..S6 (plus S7 all-red when TLC_ALL_RED_EN is defined)
//          with per-phase durations, driving registered one-hot lamps.
// Ports:   clk      - clock (1 cycle = 1 s nominal)
//          rst      - synchronous active-low reset
//          light_M1 - main road direction 1 lamp
//          light_M2 - main road direction 2 lamp
//          light_MT - main turn lamp
//          light_S  - side road lamp
// Macro:   TLC_ALL_RED_EN - inserts one all-red cycle between S6 and S1.
module traffic_light_controller
  import traffic_light_pkg::*;
#(
  parameter int T_MG  = 7,
  parameter int T_TG  = 5,
  parameter int T_SG  = 3,
  parameter int T_Y   = 2,
  parameter int CNT_W = 4
) (
  input  logic  clk,
  input  logic  rst,
  output lamp_t light_M1,
  output lamp_t light_M2,
  output lamp_t light_MT,
  output lamp_t light_S
);

  // Durations are 1..2^CNT_W, so duration-1 always fits in the timer.
  localparam logic [CNT_W-1:0] LAST_MG = CNT_W'(T_MG - 1);
  localparam logic [CNT_W-1:0] LAST_TG = CNT_W'(T_TG - 1);
  localparam logic [CNT_W-1:0] LAST_SG = CNT_W'(T_SG - 1);
  localparam logic [CNT_W-1:0] LAST_Y  = CNT_W'(T_Y - 1);

  phase_e           phase_q;
  phase_e           phase_d;
  phase_e           next_phase;
  lamps_t           lamps_q;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] last_cnt;
  logic             valid;
  logic             advance;

  tlc_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (advance),
    .count (count)
  );

  always_comb begin
    last_cnt   = LAST_MG;
    next_phase = S1;
    valid      = 1'b1;
    case (phase_q)
      S1: begin last_cnt = LAST_MG; next_phase = S2; end
      S2: begin last_cnt = LAST_Y;  next_phase = S3; end
      S3: begin last_cnt = LAST_TG; next_phase = S4; end
      S4: begin last_cnt = LAST_Y;  next_phase = S5; end
      S5: begin last_cnt = LAST_SG; next_phase = S6; end
`ifdef TLC_ALL_RED_EN
      S6: begin last_cnt = LAST_Y;  next_phase = S7; end
      S7: begin last_cnt = '0;      next_phase = S1; end
`else
      S6: begin last_cnt = LAST_Y;  next_phase = S1; end
`endif
      default: begin
        valid      = 1'b0;
        next_phase = S1;
      end
    endcase
    // An illegal encoding forces an immediate jump to S1 and clears the timer.
    advance = !valid || (count == last_cnt);
    phase_d = advance ? next_phase : phase_q;
  end

  // Lamps are registered from the next phase so they always match phase_q.
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q <= S1;
      lamps_q <= decode_phase(S1);
    end else begin
      phase_q <= phase_d;
      lamps_q <= decode_phase(phase_d);
    end
  end

  assign light_M1 = lamps_q.m1;
  assign light_M2 = lamps_q.m2;
  assign light_MT = lamps_q.mt;
  assign light_S  = lamps_q.s;

endmodule

// File: tb/tb_traffic_light_controller.sv
// tb/tb_traffic_light_controller.sv - directed bench for traffic_light_controller
module tb_traffic_light_controller;
  import traffic_light_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   passed = 0;
  int   total  = 0;
  int   fail_prints = 0;

  always #5 clk = ~clk;

  traffic_light_controller_if lamps_a();
  traffic_light_controller_if lamps_b();

  traffic_light_controller dut (
    .clk      (clk),
    .rst      (rst),
    .light_M1 (lamps_a.light_M1),
    .light_M2 (lamps_a.light_M2),
    .light_MT (lamps_a.light_MT),
    .light_S  (lamps_a.light_S)
  );

  traffic_light_controller #(.T_MG(1), .T_Y(1)) dut_short (
    .clk      (clk),
    .rst      (rst),
    .light_M1 (lamps_b.light_M1),
    .light_M2 (lamps_b.light_M2),
    .light_MT (lamps_b.light_MT),
    .light_S  (lamps_b.light_S)
  );

`ifdef TLC_ALL_RED_EN
  localparam int PERIOD_A = 22;
  localparam int PERIOD_B = 13;
  string seq_a = "1111111223333344555667";
  string seq_b = "1233333455567";
`else
  localparam int PERIOD_A = 21;
  localparam int PERIOD_B = 12;
  string seq_a = "111111122333334455566";
  string seq_b = "123333345556";
`endif

  // Hand-written lamp table, packed {M1, M2, MT, S}.
  function automatic logic [11:0] exp_lamps(byte ph);
    case (ph)
      "1":     return {3'b001, 3'b001, 3'b100, 3'b100};
      "2":     return {3'b001, 3'b010, 3'b100, 3'b100};
      "3":     return {3'b001, 3'b100, 3'b001, 3'b100};
      "4":     return {3'b010, 3'b100, 3'b010, 3'b100};
      "5":     return {3'b100, 3'b100, 3'b100, 3'b001};
      "6":     return {3'b100, 3'b100, 3'b100, 3'b010};
      default: return {3'b100, 3'b100, 3'b100, 3'b100};
    endcase
  endfunction

  function automatic logic [11:0] obs_a();
    return {lamps_a.light_M1, lamps_a.light_M2, lamps_a.light_MT, lamps_a.light_S};
  endfunction

  function automatic logic [11:0] obs_b();
    return {lamps_b.light_M1, lamps_b.light_M2, lamps_b.light_MT, lamps_b.light_S};
  endfunction

  // Leaves the bench at a falling edge, rst just released: cycle 0 of S1.
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (lamps_a.light_M1 !== 3'b001) $display("FAIL reset_M1 got %b want 001", lamps_a.light_M1);
    else passed++;
    total++;
    if (lamps_a.light_M2 !== 3'b001) $display("FAIL reset_M2 got %b want 001", lamps_a.light_M2);
    else passed++;
    total++;
    if (lamps_a.light_MT !== 3'b100) $display("FAIL reset_MT got %b want 100", lamps_a.light_MT);
    else passed++;
    total++;
    if (lamps_a.light_S !== 3'b100) $display("FAIL reset_S got %b want 100", lamps_a.light_S);
    else passed++;
    total++;
    if (obs_b() !== 12'b001_001_100_100) $display("FAIL reset_short got %b want 001001100100", obs_b());
    else passed++;
  endtask

  task automatic test_sequence();
    logic [11:0] e;
    apply_reset();
    for (int k = 0; k <= PERIOD_A; k++) begin
      e = exp_lamps(seq_a[k % PERIOD_A]);
      total++;
      if (obs_a() !== e) $display("FAIL sequence cycle %0d got %b want %b", k, obs_a(), e);
      else passed++;
      step();
    end
  endtask

  task automatic test_short_timing();
    logic [11:0] e;
    apply_reset();
    for (int k = 0; k <= PERIOD_B; k++) begin
      e = exp_lamps(seq_b[k % PERIOD_B]);
      total++;
      if (obs_b() !== e) $display("FAIL short_timing cycle %0d got %b want %b", k, obs_b(), e);
      else passed++;
      step();
    end
  endtask

  task automatic test_mid_reset();
    logic [11:0] e;
    apply_reset();
    repeat (12) step();
    e = exp_lamps("3");
    total++;
    if (obs_a() !== e) $display("FAIL mid_reset_pre got %b want %b", obs_a(), e);
    else passed++;
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int j = 0; j <= 7; j++) begin
      e = (j < 7) ? exp_lamps("1") : exp_lamps("2");
      total++;
      if (obs_a() !== e) $display("FAIL mid_reset cycle %0d got %b want %b", j, obs_a(), e);
      else passed++;
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] e;
    apply_reset();
    for (int k = 0; k < 3 * PERIOD_A; k++) begin
      e = exp_lamps(seq_a[k % PERIOD_A]);
      total++;
      if (obs_a() !== e) $display("FAIL back_to_back_a cycle %0d got %b want %b", k, obs_a(), e);
      else passed++;
      e = exp_lamps(seq_b[k % PERIOD_B]);
      total++;
      if (obs_b() !== e) $display("FAIL back_to_back_b cycle %0d got %b want %b", k, obs_b(), e);
      else passed++;
      step();
    end
  endtask

  task automatic test_safety();
    logic [11:0] o;
    logic        ok;
    apply_reset();
    for (int k = 0; k < 2000; k++) begin
      for (int d = 0; d < 2; d++) begin
        o = (d == 0) ? obs_a() : obs_b();
        ok = $onehot(o[11:9]) && $onehot(o[8:6]) && $onehot(o[5:3]) && $onehot(o[2:0]);
        if (o[2:0] != 3'b100 && (o[11:9] != 3'b100 || o[8:6] != 3'b100 || o[5:3] != 3'b100))
          ok = 1'b0;
        if (o[5:3] != 3'b100 && o[8:6] != 3'b100)
          ok = 1'b0;
        total++;
        if (!ok) begin
          if (fail_prints < 10)
            $display("FAIL safety dut %0d cycle %0d got %b want one-hot conflict-free", d, k, o);
          fail_prints++;
        end else begin
          passed++;
        end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_short_timing();
    test_mid_reset();
    test_back_to_back();
    test_safety();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/traffic_light_controller.md
TRAFFIC_LIGHT_CONTROLLER -- requirements
Module: traffic_light_controller

Interface
REQ-001 SHALL have parameter T_MG, default 7, meaning M1+M2 green duration in clock cycles.
REQ-002 SHALL have parameter T_TG, default 5, meaning MT (main-turn) green duration in cycles.
REQ-003 SHALL have parameter T_SG, default 3, meaning S (side road) green duration in cycles.
REQ-004 SHALL have parameter T_Y, default 2, meaning every yellow interval in cycles.
REQ-005 SHALL have parameter CNT_W, default 4, meaning phase timer width; every duration SHALL be in 1..2^CNT_W.
REQ-006 SHALL have port clk, input, 1 bit, meaning the single clock (1 cycle = 1 s nominal).
REQ-007 SHALL have port rst, input, 1 bit, meaning reset; reset is synchronous and active-low.
REQ-008 SHALL have ports light_M1, light_M2, light_MT, light_S, output, 3 bits each, meaning lamp state for main road dir 1, main road dir 2, main turn, side road.
REQ-009 SHALL encode lamps one-hot: RED=3'b100, YELLOW=3'b010, GREEN=3'b001; no other value SHALL ever appear.

Function
REQ-010 SHALL implement a Moore FSM with phases S1..S6 visited in fixed order S1->S2->S3->S4->S5->S6->S1.
REQ-011 S1: M1=G, M2=G, MT=R, S=R; lasts T_MG cycles.
REQ-012 S2: M1=G, M2=Y, MT=R, S=R; lasts T_Y cycles.
REQ-013 S3: M1=G, M2=R, MT=G, S=R; lasts T_TG cycles.
REQ-014 S4: M1=Y, M2=R, MT=Y, S=R; lasts T_Y cycles.
REQ-015 S5: M1=R, M2=R, MT=R, S=G; lasts T_SG cycles.
REQ-016 S6: M1=R, M2=R, MT=R, S=Y; lasts T_Y cycles.
REQ-017 Phase timer SHALL clear to 0 on entering each phase, increment each cycle, and the FSM SHALL advance on the edge where timer == duration-1, so each phase occupies exactly its duration.
REQ-018 Outputs SHALL be a pure decode of the registered state (no combinational input path); they change only on clk rising edges.
REQ-019 Full cycle SHALL be T_MG+T_TG+T_SG+3*T_Y cycles (21 with defaults) and repeat indefinitely.
REQ-020 Safety: S SHALL never be non-red while any of M1, M2, MT is non-red; MT SHALL never be non-red while M2 is non-red.

Reset
REQ-021 While rst==0 at a clk edge, state SHALL become S1 and timer 0; outputs SHALL read M1=G, M2=G, MT=R, S=R.
REQ-022 Reset asserted mid-phase SHALL abort the phase at the next edge; after release, S1 SHALL last a full T_MG cycles counted from the first edge with rst==1.
REQ-023 Out-of-range state encodings SHALL recover to S1 with timer 0 on the next edge.

Configuration
REQ-024 Macro TLC_ALL_RED_EN: when defined, an all-red clearance phase S7 (all four lamps RED, 1 cycle) SHALL be inserted between S6 and S1, giving a 22-cycle cycle with defaults; when undefined, S6 SHALL go directly to S1 and no S7 logic SHALL exist.

Structure
REQ-025 Shared package traffic_light_pkg SHALL hold the lamp encoding constants (RED/YELLOW/GREEN) and the phase-state enum typedef.
REQ-026 Phase timer SHALL be a sub-module tlc_phase_timer (inputs clk, rst, clear; output count, CNT_W bits); FSM and lamp decode stay in the top.

Verification
REQ-027 Hold rst=0 for 2 cycles -> all outputs M1=001, M2=001, MT=100, S=100.
REQ-028 Release rst, run 21 cycles -> S1 for 7 cycles, S2 2, S3 5, S4 2, S5 3, S6 2, then S1 again at cycle 21.
REQ-029 Run 2000 cycles with per-cycle checker -> safety rules of REQ-020 and one-hot encoding never violated.
REQ-030 Assert rst=0 for one cycle during S3 (cycle 12) -> next cycle S1 outputs, S1 then lasts 7 full cycles.
REQ-031 Override T_MG=1, T_Y=1 -> each of those phases lasts exactly one cycle, no phase skipped.
REQ-032 Build with TLC_ALL_RED_EN -> after S6 one cycle of all outputs 100, period 22 cycles.
